// File: rtl/pipelined_addsub_acc_pkg.sv
// pipelined_addsub_pkg: operation mode encodings shared by the add/sub/accumulate pipeline
package pipelined_addsub_pkg;
    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;
endpackage

// File: rtl/pipelined_addsub_acc_addsub_sat.sv
// addsub_sat: combinational extended add/sub with carry, overflow and optional clamping
module addsub_sat #(
    parameter int WIDTH    = 8,
    parameter bit SIGNED   = 1'b0,
    parameter bit SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf
);
    logic [WIDTH:0]   ext_a;
    logic [WIDTH:0]   ext_b;
    logic [WIDTH:0]   sum;
    logic             sgn_ovf;
    logic [WIDTH-1:0] clamp;
    // One extra bit holds the unsigned carry/borrow; signed overflow compares sign bits
    always_comb begin
        ext_a   = {SIGNED & a[WIDTH-1], a};
        ext_b   = {SIGNED & b[WIDTH-1], b};
        sum     = sub ? ext_a - ext_b : ext_a + ext_b;
        sgn_ovf = ((a[WIDTH-1] ^ b[WIDTH-1]) == sub) && (sum[WIDTH-1] != a[WIDTH-1]);
        carry   = !SIGNED && sum[WIDTH];
        ovf     = SIGNED ? sgn_ovf : sum[WIDTH];
        clamp   = SIGNED ? {a[WIDTH-1], {(WIDTH-1){~a[WIDTH-1]}}} : {WIDTH{~sub}};
        result  = (SATURATE && ovf) ? clamp : sum[WIDTH-1:0];
    end
endmodule

// File: rtl/pipelined_addsub_acc.sv
// pipelined_addsub_acc: two-stage rigid add/sub/accumulate pipeline with valid/ready handshake
module pipelined_addsub_acc
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SIGNED   = 1'b0,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_ovf
);
    logic             advance;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [1:0]       s1_mode;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    logic             is_clr;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && reset_n;
    assign is_clr   = s1_mode == MODE_CLR;

    // ACC feeds the running accumulator as the first operand and operand a as the second
    always_comb begin
        op_a = (s1_mode == MODE_ACC) ? acc : s1_a;
        op_b = (s1_mode == MODE_ACC) ? s1_a : s1_b;
    end

    addsub_sat #(.WIDTH(WIDTH), .SIGNED(SIGNED), .SATURATE(SATURATE)) u_addsub (
        .a      (op_a),
        .b      (op_b),
        .sub    (s1_mode == MODE_SUB),
        .result (sum),
        .carry  (carry),
        .ovf    (ovf)
    );

    // Stage 1 captures the offered beat whenever the whole pipeline may move
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_mode  <= MODE_ADD;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_mode  <= in_mode;
        end
    end

    // Stage 2 registers the result; the accumulator updates here so consecutive ACC beats chain
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
            out_ovf    <= 1'b0;
            acc        <= '0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= is_clr ? '0 : sum;
                out_carry  <= !is_clr && carry;
                out_ovf    <= !is_clr && ovf;
                if (s1_mode == MODE_ACC || is_clr)
                    acc <= is_clr ? '0 : sum;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_addsub_acc.sv
// tb_pipelined_addsub_acc: checks three configurations (unsigned wrap, signed sat, unsigned sat) in lockstep
module tb_pipelined_addsub_acc;
    import pipelined_addsub_pkg::*;

    typedef struct packed {logic [7:0] r; logic c; logic o;} exp_t;
    typedef struct packed {logic [1:0] m; logic [7:0] a; logic [7:0] b; exp_t w; exp_t s; exp_t u;} vec_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic [1:0] in_mode = '0;
    logic       out_ready = 1'b0;
    logic       ir_w, ir_s, ir_u, ov_w, ov_s, ov_u;
    logic [7:0] res_w, res_s, res_u;
    logic       c_w, c_s, c_u, o_w, o_s, o_u;

    int   vectors = 0;
    int   errors = 0;
    int   delivered = 0;
    exp_t q_w[$], q_s[$], q_u[$];
    logic [7:0] acc_w = '0, acc_s = '0, acc_u = '0;
    logic mv_s1 = 1'b0, mv_o = 1'b0, took = 1'b0, stalled = 1'b0;
    exp_t held;
    vec_t tab[16];

    always #5 clock = ~clock;

    pipelined_addsub_acc #(.WIDTH(8), .SIGNED(1'b0), .SATURATE(1'b0)) u_wrap (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir_w), .in_a(in_a), .in_b(in_b),
        .in_mode(in_mode), .out_valid(ov_w), .out_ready(out_ready), .out_result(res_w), .out_carry(c_w), .out_ovf(o_w));
    pipelined_addsub_acc #(.WIDTH(8), .SIGNED(1'b1), .SATURATE(1'b1)) u_ssat (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir_s), .in_a(in_a), .in_b(in_b),
        .in_mode(in_mode), .out_valid(ov_s), .out_ready(out_ready), .out_result(res_s), .out_carry(c_s), .out_ovf(o_s));
    pipelined_addsub_acc #(.WIDTH(8), .SIGNED(1'b0), .SATURATE(1'b1)) u_usat (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir_u), .in_a(in_a), .in_b(in_b),
        .in_mode(in_mode), .out_valid(ov_u), .out_ready(out_ready), .out_result(res_u), .out_carry(c_u), .out_ovf(o_u));

    // Reference: exact integer arithmetic, then range test, clamp or wrap
    function automatic exp_t model(input bit sgn, input bit sat, input logic [1:0] m,
                                   input logic [7:0] acc, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, q;
        int x, y, r, lo, hi;
        exp_t e;
        if (m == MODE_CLR) return '0;
        p = (m == MODE_ACC) ? acc : a;
        q = (m == MODE_ACC) ? a : b;
        if (sgn) begin x = int'($signed(p)); y = int'($signed(q)); end
        else begin x = int'(p); y = int'(q); end
        r = (m == MODE_SUB) ? x - y : x + y;
        lo = sgn ? -128 : 0;
        hi = sgn ? 127 : 255;
        e.o = (r < lo) || (r > hi);
        e.c = !sgn && e.o;
        e.r = (sat && e.o) ? 8'(r > hi ? hi : lo) : 8'(r);
        return e;
    endfunction

    function automatic vec_t mk(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                                input exp_t w, input exp_t s, input exp_t u);
        return {m, a, b, w, s, u};
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, settle, compare against the model, then advance the model
    task automatic step(input logic v, input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                        input logic ordy, input logic rn, input bit use_tab, input vec_t t);
        exp_t ew, es, eu;
        logic adv;
        @(negedge clock);
        in_valid = v; in_mode = m; in_a = a; in_b = b; out_ready = ordy; reset_n = rn;
        #1;
        chk("out_valid", {ov_w, ov_s, ov_u}, {3{mv_o}});
        chk("in_ready", {ir_w, ir_s, ir_u}, {3{rn && (!mv_o || ordy)}});
        took = 1'b0;
        if (!rn) begin
            q_w.delete(); q_s.delete(); q_u.delete();
            acc_w = '0; acc_s = '0; acc_u = '0;
            mv_s1 = 1'b0; mv_o = 1'b0; stalled = 1'b0;
            return;
        end
        adv = !mv_o || ordy;
        if (stalled) chk("held", {res_w, c_w, o_w}, held);
        stalled = mv_o && !ordy;
        held = {res_w, c_w, o_w};
        if (mv_o && ordy) begin
            delivered++;
            vectors++;
            if (q_w.size() == 0) begin
                errors++;
                $display("FAIL extra_beat: got out_valid with no beat outstanding at %0t", $time);
            end else begin
                vectors--;
                ew = q_w.pop_front(); es = q_s.pop_front(); eu = q_u.pop_front();
                chk("wrap_result", {res_w, c_w, o_w}, ew);
                chk("ssat_result", {res_s, c_s, o_s}, es);
                chk("usat_result", {res_u, c_u, o_u}, eu);
            end
        end
        if (v && adv) begin
            took = 1'b1;
            if (use_tab) begin ew = t.w; es = t.s; eu = t.u; end
            else begin
                ew = model(1'b0, 1'b0, m, acc_w, a, b);
                es = model(1'b1, 1'b1, m, acc_s, a, b);
                eu = model(1'b0, 1'b1, m, acc_u, a, b);
            end
            q_w.push_back(ew); q_s.push_back(es); q_u.push_back(eu);
            if (m[1]) begin acc_w = ew.r; acc_s = es.r; acc_u = eu.r; end
        end
        if (adv) begin mv_o = mv_s1; mv_s1 = v; end
    endtask

    task automatic beat(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
        step(1'b1, m, a, b, 1'b1, 1'b1, 1'b0, '0);
    endtask

    task automatic idle(input logic ordy, input logic rn);
        step(1'b0, MODE_ADD, 8'h00, 8'h00, ordy, rn, 1'b0, '0);
    endtask

    initial begin
        int d0, accepted, cyc, k;
        logic pv, pr;
        logic [1:0] pm;
        logic [7:0] pa, pb;
        logic bp_ready[11];

        tab[0]  = mk(MODE_ADD, 8'd200, 8'd100, {8'd44, 2'b11},  {8'd44, 2'b00},  {8'd255, 2'b11});
        tab[1]  = mk(MODE_ADD, 8'd100, 8'd100, {8'd200, 2'b00}, {8'd127, 2'b01}, {8'd200, 2'b00});
        tab[2]  = mk(MODE_SUB, 8'd156, 8'd100, {8'd56, 2'b00},  {8'd128, 2'b01}, {8'd56, 2'b00});
        tab[3]  = mk(MODE_SUB, 8'd3, 8'd5,     {8'd254, 2'b11}, {8'd254, 2'b00}, {8'd0, 2'b11});
        tab[4]  = mk(MODE_CLR, 8'h55, 8'h66,   {8'd0, 2'b00},   {8'd0, 2'b00},   {8'd0, 2'b00});
        tab[5]  = mk(MODE_ACC, 8'd3, 8'hAA,    {8'd3, 2'b00},   {8'd3, 2'b00},   {8'd3, 2'b00});
        tab[6]  = mk(MODE_ACC, 8'd4, 8'h11,    {8'd7, 2'b00},   {8'd7, 2'b00},   {8'd7, 2'b00});
        tab[7]  = mk(MODE_ACC, 8'd250, 8'h00,  {8'd1, 2'b11},   {8'd1, 2'b00},   {8'd255, 2'b11});
        tab[8]  = mk(MODE_ACC, 8'd127, 8'h33,  {8'd128, 2'b00}, {8'd127, 2'b01}, {8'd255, 2'b11});
        tab[9]  = mk(MODE_CLR, 8'd1, 8'd2,     {8'd0, 2'b00},   {8'd0, 2'b00},   {8'd0, 2'b00});
        tab[10] = mk(MODE_ACC, 8'd5, 8'hFF,    {8'd5, 2'b00},   {8'd5, 2'b00},   {8'd5, 2'b00});
        tab[11] = mk(MODE_ADD, 8'd255, 8'd1,   {8'd0, 2'b11},   {8'd0, 2'b00},   {8'd255, 2'b11});
        tab[12] = mk(MODE_SUB, 8'd128, 8'd1,   {8'd127, 2'b00}, {8'd128, 2'b01}, {8'd127, 2'b00});
        tab[13] = mk(MODE_ADD, 8'd128, 8'd128, {8'd0, 2'b11},   {8'd128, 2'b01}, {8'd255, 2'b11});
        tab[14] = mk(MODE_ADD, 8'd127, 8'd1,   {8'd128, 2'b00}, {8'd127, 2'b01}, {8'd128, 2'b00});
        tab[15] = mk(MODE_ACC, 8'd1, 8'hFF,    {8'd6, 2'b00},   {8'd6, 2'b00},   {8'd6, 2'b00});

        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        chk("reset_outputs", {res_w, c_w, o_w, res_s, c_s, o_s, res_u, c_u, o_u}, '0);

        // Directed table, streamed back to back at full rate
        for (int i = 0; i < 16; i++)
            step(1'b1, tab[i].m, tab[i].a, tab[i].b, 1'b1, 1'b1, 1'b1, tab[i]);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);

        // Backpressure: four ADD beats with a three-cycle consumer stall mid-stream
        bp_ready = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        d0 = delivered;
        k = 0;
        for (int c = 0; c < 11; c++) begin
            step(k < 4, MODE_ADD, 8'(40 * k + 7), 8'(k + 200), bp_ready[c], 1'b1, 1'b0, '0);
            if (took) k++;
        end
        chk("bp_delivered", delivered - d0, 4);

        // Reset with two beats in flight; the accumulator must restart from zero
        beat(MODE_ACC, 8'd7, 8'd0);
        beat(MODE_ADD, 8'd1, 8'd2);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        chk("post_reset_valid", ov_w, 1'b0);
        beat(MODE_ACC, 8'd9, 8'd0);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        chk("post_reset_acc", res_w, 8'd9);
        idle(1'b1, 1'b1);

        // Random traffic with random stalls on both sides; offered beats are held until taken
        accepted = 0;
        cyc = 0;
        pv = 1'b0; pm = '0; pa = '0; pb = '0;
        while (accepted < 1000 && cyc < 20000) begin
            if (!(pv && !took)) begin
                pv = $urandom_range(0, 3) != 0;
                pm = 2'($urandom);
                pa = 8'($urandom);
                pb = 8'($urandom);
            end
            pr = $urandom_range(0, 3) != 0;
            step(pv, pm, pa, pb, pr, 1'b1, 1'b0, '0);
            if (took) accepted++;
            cyc++;
        end
        if (accepted < 1000) begin
            errors++;
            $display("FAIL random_timeout: got %0d accepted beats expected 1000", accepted);
        end
        repeat (4) idle(1'b1, 1'b1);
        chk("drained", q_w.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
